// File: rtl/regfile_wr_queue_if.sv
// Request handshake between execute stage and the write-back queue.
// Master drives valid/addr/data; slave answers with ready.
interface regfile_wr_queue_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_wr_queue.sv
// Write-back queue in front of the register array.
// FIFO of (addr,data), one drain per cycle, one-hot select, forwarding lookup.
module regfile_wr_queue #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 5,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    regfile_wr_queue_if.slave        req,
    input  logic                     stall,
    output logic [NUM_REGS-1:0]      chosen,
    output logic                     w_en,
    output logic [DATA_W-1:0]        w_data,
    input  logic [ADDR_W-1:0]        pend_addr,
    output logic                     pend_hit,
    output logic [DATA_W-1:0]        pend_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0]   r_addr [DEPTH];
    logic [DATA_W-1:0]   r_data [DEPTH];
    logic [PW-1:0]       r_wp;
    logic [PW-1:0]       r_rp;
    logic [CW-1:0]       r_cnt;
    logic [NUM_REGS-1:0] r_chosen;
    logic                r_w_en;
    logic [DATA_W-1:0]   r_w_data;
    logic                r_err;

    logic                w_full;
    logic                w_empty;
    logic                w_in_range;
    logic                w_acc;
    logic                w_push;
    logic                w_pop;
    logic [NUM_REGS-1:0] w_head_sel;

    assign w_full        = (r_cnt == CW'(DEPTH));
    assign w_empty       = (r_cnt == '0);
    assign req.req_ready = !w_full;
    assign w_in_range    = (int'(req.req_addr) < NUM_REGS);
    assign w_acc         = req.req_valid && !w_full;
    assign w_push        = w_acc && w_in_range;
    assign w_pop         = !w_empty && !stall;

    assign chosen = r_chosen;
    assign w_en   = r_w_en;
    assign w_data = r_w_data;
    assign count  = r_cnt;
    assign err    = r_err;

    // Decode the head entry's address into a one-hot register select
    always_comb begin
        w_head_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_head_sel[i] = (r_addr[r_rp] == ADDR_W'(i));
        end
    end

    // Queue storage and pointers; out-of-range requests are swallowed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_addr[r_wp] <= req.req_addr;
                r_data[r_wp] <= req.req_data;
                r_wp         <= r_wp + PW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Register-array drive stage: one-cycle strobe per popped entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_w_en    <= 1'b0;
            r_chosen  <= '0;
            r_w_data  <= '0;
        end else if (w_pop) begin
            r_w_en    <= 1'b1;
            r_chosen  <= w_head_sel;
            r_w_data  <= r_data[r_rp];
        end else begin
            r_w_en    <= 1'b0;
            r_chosen  <= '0;
        end
    end

    // Sticky flag for any accepted request aimed past the register file
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_acc && !w_in_range) begin
            r_err <= 1'b1;
        end
    end

    // Lookup: output stage is oldest, then queue entries oldest to newest
    always_comb begin
        logic [PW-1:0] v_idx;
        v_idx     = '0;
        pend_hit  = 1'b0;
        pend_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_w_en && r_chosen[i] && pend_addr == ADDR_W'(i)) begin
                pend_hit  = 1'b1;
                pend_data = r_w_data;
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_rp + PW'(k);
            if (CW'(k) < r_cnt && r_addr[v_idx] == pend_addr) begin
                pend_hit  = 1'b1;
                pend_data = r_data[v_idx];
            end
        end
    end
endmodule

// File: tb/tb_regfile_wr_queue.sv
// Bench for regfile_wr_queue: directed stimulus, scoreboard of expected
// register writes, monitor compares every w_en pulse in order.
module tb_regfile_wr_queue;
    localparam int NR = 6;
    localparam int AW = 3;
    localparam int DW = 5;
    localparam int DP = 4;

    logic          clk;
    logic          rst;
    logic          stall;
    logic [NR-1:0] chosen;
    logic          w_en;
    logic [DW-1:0] w_data;
    logic [AW-1:0] pend_addr;
    logic          pend_hit;
    logic [DW-1:0] pend_data;
    logic [2:0]    count;
    logic          err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [NR+DW-1:0] sb [$];

    regfile_wr_queue_if #(.ADDR_W(AW), .DATA_W(DW)) rq ();

    regfile_wr_queue #(
        .NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (rq.slave),
        .stall     (stall),
        .chosen    (chosen),
        .w_en      (w_en),
        .w_data    (w_data),
        .pend_addr (pend_addr),
        .pend_hit  (pend_hit),
        .pend_data (pend_data),
        .count     (count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [NR+DW-1:0] wr(input int a, input int d);
        logic [NR-1:0] oh;
        oh = '0;
        oh[a] = 1'b1;
        return {oh, DW'(d)};
    endfunction

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst && w_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {21'd0, chosen, w_data}, 32'hFFFF_FFFF);
            end else begin
                chk("write", {21'd0, chosen, w_data}, {21'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int ad [4];
        int da [4];
        ad = '{1, 4, 0, 5};
        da = '{5'h0A, 5'h0B, 5'h0C, 5'h1D};
        rst          = 1'b0;
        stall        = 1'b0;
        pend_addr    = '0;
        rq.req_valid = 1'b0;
        rq.req_addr  = '0;
        rq.req_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        @(negedge clk);
        chk("rst_w_en", 32'(w_en), 0);
        chk("rst_chosen", 32'(chosen), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(rq.req_ready), 1);
        chk("rst_err", 32'(err), 0);

        rq.req_valid = 1'b1;
        rq.req_addr  = 3'd3;
        rq.req_data  = 5'h15;
        sb.push_back(wr(3, 5'h15));
        @(negedge clk);
        rq.req_valid = 1'b0;
        chk("single_count1", 32'(count), 1);
        @(negedge clk);
        chk("single_w_en", 32'(w_en), 1);
        chk("single_count0", 32'(count), 0);
        @(negedge clk);
        chk("single_w_en_off", 32'(w_en), 0);

        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rq.req_valid = 1'b1;
            rq.req_addr  = AW'(ad[i]);
            rq.req_data  = DW'(da[i]);
            sb.push_back(wr(ad[i], da[i]));
            @(negedge clk);
        end
        rq.req_addr = 3'd2;
        rq.req_data = 5'h1F;
        chk("fill_count", 32'(count), 4);
        chk("fill_ready", 32'(rq.req_ready), 0);
        chk("fill_w_en", 32'(w_en), 0);
        @(negedge clk);
        rq.req_valid = 1'b0;
        chk("full_no_push", 32'(count), 4);
        stall = 1'b0;
        @(negedge clk);
        chk("drain_ready", 32'(rq.req_ready), 1);
        chk("drain_count3", 32'(count), 3);
        repeat (3) @(negedge clk);
        chk("drain_count0", 32'(count), 0);
        @(negedge clk);
        chk("drain_w_en_off", 32'(w_en), 0);

        stall = 1'b1;
        rq.req_valid = 1'b1;
        rq.req_addr  = 3'd2;
        rq.req_data  = 5'd1;
        sb.push_back(wr(2, 1));
        @(negedge clk);
        rq.req_data  = 5'd9;
        sb.push_back(wr(2, 9));
        @(negedge clk);
        rq.req_valid = 1'b0;
        pend_addr    = 3'd2;
        #1;
        chk("fwd_hit", 32'(pend_hit), 1);
        chk("fwd_data", 32'(pend_data), 9);
        pend_addr = 3'd5;
        #1;
        chk("miss_hit", 32'(pend_hit), 0);
        chk("miss_data", 32'(pend_data), 0);
        pend_addr = 3'd2;
        stall     = 1'b0;
        @(negedge clk);
        #1;
        chk("fwd_q_over_out", 32'(pend_data), 9);
        @(negedge clk);
        #1;
        chk("fwd_out_hit", 32'(pend_hit), 1);
        chk("fwd_out_data", 32'(pend_data), 9);
        chk("fwd_count", 32'(count), 0);
        @(negedge clk);
        #1;
        chk("fwd_gone", 32'(pend_hit), 0);

        rq.req_valid = 1'b1;
        rq.req_addr  = 3'd6;
        rq.req_data  = 5'h03;
        @(negedge clk);
        rq.req_valid = 1'b0;
        chk("err_count", 32'(count), 0);
        chk("err_set", 32'(err), 1);
        rq.req_valid = 1'b1;
        rq.req_addr  = 3'd5;
        rq.req_data  = 5'h11;
        sb.push_back(wr(5, 5'h11));
        @(negedge clk);
        rq.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("err_sticky", 32'(err), 1);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rq.req_valid = 1'b1;
            rq.req_addr  = AW'(i + 1);
            rq.req_data  = DW'(20 + i);
            if (i == 0) sb.push_back(wr(1, 20));
            @(negedge clk);
        end
        rq.req_valid = 1'b0;
        stall        = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_w_en", 32'(w_en), 0);
        chk("mid_rst_chosen", 32'(chosen), 0);
        chk("mid_rst_count", 32'(count), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_err", 32'(err), 0);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
